keypad_entry_unit: RTL and testbench

//  Input-side counterpart of the output/display path: accepts keypad codes, builds signed
//  10-digit BCD entry (BCD_IU, sign nibble + 10 digits) for display, and on ENTER converts it

---
 rtl/keypad_entry_unit.sv | 178 +++++++++++++++++
 tb/tb_keypad_entry_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_unit.sv
// Keypad entry: builds a signed BCD number from key codes and, on ENTER,
// converts it MSD-first into a saturated two's-complement value.
module keypad_entry_unit #(
  parameter int DIGITS = 10,
  parameter int WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS+3:0]   BCD_IU,
  output logic [3:0]            digit_count,
  output logic [WIDTH-1:0]      value_out,
  output logic                  value_valid,
  output logic                  overflow,
  output logic                  busy
);

  localparam int DW = 4 * DIGITS;
  localparam int AW = 36;
  localparam int IW = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    dig_q, dig_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             fresh_q, fresh_d;
  logic [DW-1:0]    wdig_q, wdig_d;
  logic             wneg_q, wneg_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;

  logic [DW-1:0]    dig_t;
  logic [3:0]       cnt_t;
  logic [3:0]       cur;
  logic [AW-1:0]    lim;
  logic [AW-1:0]    acc_neg;
  logic             is_dig;

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    fresh_d = fresh_q;
    wdig_d  = wdig_q;
    wneg_d  = wneg_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    val_d   = val_q;
    vld_d   = 1'b0;
    ovf_d   = ovf_q;
    dig_t   = dig_q;
    cnt_t   = cnt_q;
    is_dig  = key_code <= 4'd9;
    cur     = wdig_q[{idx_q, 2'b00} +: 4];
    lim     = (AW'(1) << (WIDTH - 1)) - (wneg_q ? AW'(0) : AW'(1));
    acc_neg = '0;

    unique case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          unique case (1'b1)
            is_dig: begin
              // A digit after a finished conversion starts a new entry
              dig_t   = fresh_q ? '0 : dig_q;
              cnt_t   = fresh_q ? 4'd0 : cnt_q;
              neg_d   = fresh_q ? 1'b0 : neg_q;
              fresh_d = 1'b0;
              if (!(cnt_t == 4'd0 && key_code == 4'd0)
                  && cnt_t < 4'(DIGITS)) begin
                dig_t = {dig_t[DW-5:0], key_code};
                cnt_t = cnt_t + 4'd1;
              end
              dig_d = dig_t;
              cnt_d = cnt_t;
            end
            key_code == 4'hA: begin
              neg_d   = ~neg_q;
              fresh_d = 1'b0;
            end
            key_code == 4'hB: begin
              fresh_d = 1'b0;
              if (cnt_q != 4'd0) begin
                dig_d = dig_q >> 4;
                cnt_d = cnt_q - 4'd1;
              end
            end
            key_code == 4'hC: begin
              dig_d   = '0;
              cnt_d   = 4'd0;
              neg_d   = 1'b0;
              fresh_d = 1'b0;
            end
            key_code == 4'hD: begin
              wdig_d  = dig_q;
              wneg_d  = neg_q;
              acc_d   = '0;
              idx_d   = IW'(DIGITS - 1);
              state_d = S_CONV;
            end
            default: ;
          endcase
        end
      end
      S_CONV: begin
        acc_d = acc_q * AW'(10) + AW'(cur);
        idx_d = idx_q - IW'(1);
        // Result is registered on the last step so it is valid in DONE
        if (idx_q == '0) begin
          state_d = S_DONE;
          vld_d   = 1'b1;
          acc_neg = -acc_d;
          if (acc_d > lim) begin
            ovf_d = 1'b1;
            val_d = wneg_q ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
          end else begin
            ovf_d = 1'b0;
            val_d = wneg_q ? acc_neg[WIDTH-1:0] : acc_d[WIDTH-1:0];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        fresh_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dig_q   <= '0;
      cnt_q   <= 4'd0;
      neg_q   <= 1'b0;
      fresh_q <= 1'b0;
      wdig_q  <= '0;
      wneg_q  <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      fresh_q <= fresh_d;
      wdig_q  <= wdig_d;
      wneg_q  <= wneg_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign BCD_IU      = {neg_q ? 4'hA : 4'hF, dig_q};
  assign digit_count = cnt_q;
  assign value_out   = val_q;
  assign value_valid = vld_q;
  assign overflow    = ovf_q;
  assign busy        = state_q != S_IDLE;

endmodule

// File: tb/tb_keypad_entry_unit.sv
// Directed bench for keypad_entry_unit: key sequences with
// hand-computed BCD and binary results.
module tb_keypad_entry_unit;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [43:0] BCD_IU;
  logic [3:0]  digit_count;
  logic [31:0] value_out;
  logic        value_valid;
  logic        overflow;
  logic        busy;

  int total = 0;
  int bad   = 0;

  keypad_entry_unit dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .BCD_IU      (BCD_IU),
    .digit_count (digit_count),
    .value_out   (value_out),
    .value_valid (value_valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) begin
      press(4'(s[i] - 8'd48));
    end
  endtask

  // Waits for the result pulse; cyc=1 is the first cycle after ENTER
  task automatic wait_result(input string tag, input logic [31:0] ev,
                             input logic eo, input bit lat);
    int cyc;
    cyc = 1;
    while (!value_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_vv"}, 64'(value_valid), 64'd1);
    if (lat) chk({tag, "_lat"}, 64'(cyc), 64'd11);
    chk({tag, "_val"}, 64'(value_out), 64'(ev));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(value_valid), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic enter(input string tag, input logic [31:0] ev,
                       input logic eo, input bit lat);
    press(4'hD);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_result(tag, ev, eo, lat);
  endtask

  initial begin
    int pulses;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", 64'(BCD_IU), 64'hF_00000_00000);
    chk("rst_cnt", 64'(digit_count), 64'd0);
    chk("rst_val", 64'(value_out), 64'd0);
    chk("rst_flags", 64'({value_valid, overflow, busy}), 64'd0);
    rst = 1'b0;

    keys("123");
    chk("t1_bcd", 64'(BCD_IU), 64'hF_00000_00123);
    chk("t1_cnt", 64'(digit_count), 64'd3);
    enter("t1", 32'd123, 1'b0, 1'b1);

    press(4'hC);
    keys("2147483648");
    press(4'hA);
    chk("t2_bcd", 64'(BCD_IU), 64'hA_21474_83648);
    enter("t2n", 32'h8000_0000, 1'b0, 1'b0);
    press(4'hA);
    chk("t2_bcdp", 64'(BCD_IU), 64'hF_21474_83648);
    enter("t2p", 32'h7FFF_FFFF, 1'b1, 1'b0);

    press(4'hC);
    keys("99999999999");
    chk("t3_cnt", 64'(digit_count), 64'd10);
    chk("t3_dig", 64'(BCD_IU[39:0]), 64'h99999_99999);
    enter("t3", 32'h7FFF_FFFF, 1'b1, 1'b0);

    keys("5");
    chk("neg5_bcd", 64'(BCD_IU), 64'hF_00000_00005);
    press(4'hA);
    enter("neg5", 32'hFFFF_FFFB, 1'b0, 1'b0);

    press(4'hC);
    keys("0056");
    press(4'hB);
    keys("7");
    chk("t4_cnt", 64'(digit_count), 64'd2);
    chk("t4_dig", 64'(BCD_IU[7:0]), 64'h57);
    press(4'hA);
    chk("t4_sign", 64'(BCD_IU[43:40]), 64'hA);
    press(4'hC);
    chk("t4_clr", 64'(BCD_IU), 64'hF_00000_00000);
    chk("t4_ccnt", 64'(digit_count), 64'd0);
    chk("t4_held", 64'(value_out), 64'hFFFF_FFFB);

    press(4'hA);
    enter("neg0", 32'd0, 1'b0, 1'b0);

    keys("8");
    chk("t6_cnt", 64'(digit_count), 64'd1);
    chk("t6_bcd", 64'(BCD_IU), 64'hF_00000_00008);

    keys("61");
    press(4'hD);
    press(4'h4);
    press(4'hC);
    wait_result("t5", 32'd861, 1'b0, 1'b0);
    chk("t5_bcd", 64'(BCD_IU), 64'hF_00000_00861);
    chk("t5_cnt", 64'(digit_count), 64'd3);

    press(4'hD);
    repeat (4) @(negedge clk);
    chk("t5_midconv", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (value_valid) pulses++;
      @(negedge clk);
    end
    chk("t5_nopulse", 64'(pulses), 64'd0);
    chk("t5_rbcd", 64'(BCD_IU), 64'hF_00000_00000);
    chk("t5_rcnt", 64'(digit_count), 64'd0);
    chk("t5_rval", 64'(value_out), 64'd0);
    chk("t5_rflags", 64'({value_valid, overflow, busy}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
